uop_mport_queue: RTL and testbench

//   Parametrised multi-port circular FIFO between decode/crack and rename.

---
 rtl/uop_mport_queue.sv | 147 ++++++++++++++
 tb/tb_uop_mport_queue.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uop_mport_queue.sv
// uop_mport_queue
//   Multi-port circular FIFO between decode/crack and rename. Accepts up to
//   WIDTH entries per cycle, retires up to WIDTH entries per cycle, and
//   presents the oldest WIDTH entries with a per-lane valid mask. Requests
//   beyond the available space or occupancy are clamped, and the first
//   occurrence of each kind is latched in a sticky error flag. DEPTH does not
//   have to be a power of two.
//
// Ports
//   clk_in        clock, rising edge
//   rst_in        asynchronous active-high reset
//   flush_in      synchronous flush; empties the queue
//   enq_data_in   WIDTH lanes of DATA_W bits; lane 0 is the oldest
//   enq_cnt_in    requested pushes this cycle
//   deq_cnt_in    requested pops this cycle
//   enq_acc_out   pushes accepted this cycle (combinational)
//   deq_data_out  lane i = entry at head+i (mod DEPTH)
//   deq_vld_out   bit i set when count > i
//   count_out     occupied entries
//   free_out      DEPTH - count
//   full_out      count == DEPTH
//   empty_out     count == 0
//   ovf_err_out   sticky: a push request exceeded the free space
//   udf_err_out   sticky: a pop request exceeded the occupancy
module uop_mport_queue #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 4,
  localparam int CW = $clog2(WIDTH + 1),
  localparam int NW = $clog2(DEPTH + 1)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    flush_in,
  input  logic [WIDTH*DATA_W-1:0] enq_data_in,
  input  logic [CW-1:0]           enq_cnt_in,
  input  logic [CW-1:0]           deq_cnt_in,
  output logic [CW-1:0]           enq_acc_out,
  output logic [WIDTH*DATA_W-1:0] deq_data_out,
  output logic [WIDTH-1:0]        deq_vld_out,
  output logic [NW-1:0]           count_out,
  output logic [NW-1:0]           free_out,
  output logic                    full_out,
  output logic                    empty_out,
  output logic                    ovf_err_out,
  output logic                    udf_err_out
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so ptr + offset (both < DEPTH) never overflows before the wrap.
  localparam int SW = PW + 1;
  localparam int XW = (CW > NW) ? CW : NW;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [NW-1:0]     count;
  logic [NW-1:0]     free;
  logic [XW-1:0]     enq_req;
  logic [XW-1:0]     deq_req;
  logic [XW-1:0]     free_x;
  logic [XW-1:0]     count_x;
  logic [CW-1:0]     enq_acc;
  logic [CW-1:0]     deq_acc;
  logic              ovf_req;
  logic              udf_req;
  logic              ovf_err;
  logic              udf_err;

  // Modulo-DEPTH pointer advance by compare-and-subtract; exact for any DEPTH.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] ptr,
                                            input logic [SW-1:0] n);
    logic [SW-1:0] sum;
    sum = SW'(ptr) + n;
    if (sum >= SW'(DEPTH)) sum = sum - SW'(DEPTH);
    return sum[PW-1:0];
  endfunction

  // Accept counts come from start-of-cycle state only, so a full queue
  // cannot reuse a slot being popped and an empty queue cannot bypass.
  assign free    = NW'(DEPTH) - count;
  assign enq_req = XW'(enq_cnt_in);
  assign deq_req = XW'(deq_cnt_in);
  assign free_x  = XW'(free);
  assign count_x = XW'(count);
  assign ovf_req = enq_req > free_x;
  assign udf_req = deq_req > count_x;
  assign enq_acc = ovf_req ? CW'(free_x) : enq_cnt_in;
  assign deq_acc = udf_req ? CW'(count_x) : deq_cnt_in;

  assign enq_acc_out = flush_in ? '0 : enq_acc;
  assign count_out   = count;
  assign free_out    = free;
  assign full_out    = (count == NW'(DEPTH));
  assign empty_out   = (count == '0);
  assign ovf_err_out = ovf_err;
  assign udf_err_out = udf_err;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else if (flush_in) begin
      // Flush drops pending traffic but leaves the error history intact.
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= ptr_add(head, SW'(deq_acc));
      tail  <= ptr_add(tail, SW'(enq_acc));
      count <= count + NW'(enq_acc) - NW'(deq_acc);
      if (ovf_req) ovf_err <= 1'b1;
      if (udf_req) udf_err <= 1'b1;
    end
  end

  // Storage is deliberately not reset; lanes outside deq_vld_out are don't-care.
  always_ff @(posedge clk_in) begin
    if (!rst_in && !flush_in) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (CW'(i) < enq_acc) mem[ptr_add(tail, SW'(i))] <= enq_data_in[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    deq_data_out = '0;
    deq_vld_out  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      deq_data_out[i*DATA_W +: DATA_W] = mem[ptr_add(head, SW'(i))];
      deq_vld_out[i]                   = (count > NW'(i));
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      assert (int'(count) <= DEPTH);
      assert (((int'(tail) - int'(head) + DEPTH) % DEPTH) == (int'(count) % DEPTH));
    end
  end
`endif

endmodule

// File: tb/tb_uop_mport_queue.sv
module tb_uop_mport_queue;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 6;
  localparam int WIDTH  = 4;
  localparam int CW     = $clog2(WIDTH + 1);
  localparam int NW     = $clog2(DEPTH + 1);

  logic                    clk_in = 1'b0;
  logic                    rst_in = 1'b1;
  logic                    flush_in = 1'b0;
  logic [WIDTH*DATA_W-1:0] enq_data_in = '0;
  logic [CW-1:0]           enq_cnt_in = '0;
  logic [CW-1:0]           deq_cnt_in = '0;
  logic [CW-1:0]           enq_acc_out;
  logic [WIDTH*DATA_W-1:0] deq_data_out;
  logic [WIDTH-1:0]        deq_vld_out;
  logic [NW-1:0]           count_out;
  logic [NW-1:0]           free_out;
  logic                    full_out;
  logic                    empty_out;
  logic                    ovf_err_out;
  logic                    udf_err_out;

  always #5 clk_in = ~clk_in;

  uop_mport_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .flush_in    (flush_in),
    .enq_data_in (enq_data_in),
    .enq_cnt_in  (enq_cnt_in),
    .deq_cnt_in  (deq_cnt_in),
    .enq_acc_out (enq_acc_out),
    .deq_data_out(deq_data_out),
    .deq_vld_out (deq_vld_out),
    .count_out   (count_out),
    .free_out    (free_out),
    .full_out    (full_out),
    .empty_out   (empty_out),
    .ovf_err_out (ovf_err_out),
    .udf_err_out (udf_err_out)
  );

  typedef struct {
    int                      acc;
    int                      cnt;
    bit                      ovf;
    bit                      udf;
    logic [WIDTH*DATA_W-1:0] lanes;
  } exp_t;

  exp_t              exp_q[$];
  exp_t              pend;
  bit                pend_v = 1'b0;
  logic [DATA_W-1:0] mdl[$];
  int                tag = 0;
  int                n_cmp = 0;
  int                n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_post(input exp_t e);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < WIDTH; i++) v[i] = (e.cnt > i);
    chk("count", 64'(count_out), 64'(e.cnt));
    chk("free", 64'(free_out), 64'(DEPTH - e.cnt));
    chk("full", 64'(full_out), 64'(e.cnt == DEPTH));
    chk("empty", 64'(empty_out), 64'(e.cnt == 0));
    chk("vld", 64'(deq_vld_out), 64'(v));
    chk("ovf_err", 64'(ovf_err_out), 64'(e.ovf));
    chk("udf_err", 64'(udf_err_out), 64'(e.udf));
    for (int i = 0; i < WIDTH; i++) begin
      if (i < e.cnt)
        chk($sformatf("lane%0d", i), 64'(deq_data_out[i*DATA_W +: DATA_W]),
            64'(e.lanes[i*DATA_W +: DATA_W]));
    end
  endtask

  // Monitor: post-edge state of the previous request, then the
  // combinational accept count of the request now on the inputs.
  initial forever begin
    @(negedge clk_in);
    if (pend_v) begin
      check_post(pend);
      pend_v = 1'b0;
    end
    if (exp_q.size() > 0) begin
      pend = exp_q.pop_front();
      chk("enq_acc", 64'(enq_acc_out), 64'(pend.acc));
      pend_v = 1'b1;
    end
  end

  // One cycle of stimulus with hand-computed accept counts and results.
  task automatic drive(input int enq, input int deq, input bit fl, input int e_acc,
                       input int e_deq, input int e_cnt, input bit e_ovf, input bit e_udf);
    exp_t e;
    @(posedge clk_in);
    #1;
    for (int i = 0; i < WIDTH; i++)
      enq_data_in[i*DATA_W +: DATA_W] = DATA_W'(32'hA000 + tag + i);
    tag += WIDTH;
    enq_cnt_in = CW'(enq);
    deq_cnt_in = CW'(deq);
    flush_in   = fl;
    if (fl) mdl.delete();
    else begin
      for (int i = 0; i < e_deq; i++) void'(mdl.pop_front());
      for (int i = 0; i < e_acc; i++) mdl.push_back(enq_data_in[i*DATA_W +: DATA_W]);
    end
    e.acc   = e_acc;
    e.cnt   = e_cnt;
    e.ovf   = e_ovf;
    e.udf   = e_udf;
    e.lanes = '0;
    for (int i = 0; i < WIDTH; i++)
      if (i < mdl.size()) e.lanes[i*DATA_W +: DATA_W] = mdl[i];
    exp_q.push_back(e);
  endtask

  task automatic idle_drain();
    int k;
    @(posedge clk_in);
    #1;
    enq_cnt_in = '0;
    deq_cnt_in = '0;
    flush_in   = 1'b0;
    k = 0;
    while ((exp_q.size() != 0 || pend_v) && k < 10) begin
      @(negedge clk_in);
      #1;
      k++;
    end
    if (exp_q.size() != 0 || pend_v) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    #1;
    chk("rst_count", 64'(count_out), 64'd0);
    chk("rst_free", 64'(free_out), 64'd6);
    chk("rst_empty", 64'(empty_out), 64'd1);
    chk("rst_full", 64'(full_out), 64'd0);
    chk("rst_vld", 64'(deq_vld_out), 64'd0);
    chk("rst_ovf", 64'(ovf_err_out), 64'd0);
    chk("rst_udf", 64'(udf_err_out), 64'd0);

    //    enq deq fl acc deq cnt ovf udf
    drive(4,  0,  0, 4,  0,  4,  0,  0);   // A0..A3
    drive(4,  0,  0, 2,  0,  6,  1,  0);   // only 2 fit -> full, overflow
    drive(4,  3,  0, 0,  3,  3,  1,  0);   // full: push refused, pop 3
    for (int c = 0; c < 10; c++)
      drive(3, 3, 0, 3, 3, 3, 1, 0);       // steady 3/3 across the wrap
    drive(0,  3,  0, 0,  3,  0,  1,  0);   // drain
    drive(2,  2,  0, 2,  0,  2,  1,  1);   // empty: no bypass, underflow
    drive(3,  0,  1, 0,  0,  0,  1,  1);   // flush wins, flags kept
    drive(3,  0,  0, 3,  0,  3,  1,  1);
    idle_drain();

    // Asynchronous reset between clock edges discards contents at once.
    @(negedge clk_in);
    #2;
    rst_in = 1'b1;
    #1;
    chk("arst_count", 64'(count_out), 64'd0);
    chk("arst_empty", 64'(empty_out), 64'd1);
    chk("arst_vld", 64'(deq_vld_out), 64'd0);
    chk("arst_ovf", 64'(ovf_err_out), 64'd0);
    chk("arst_udf", 64'(udf_err_out), 64'd0);
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    mdl.delete();

    drive(1,  0,  0, 1,  0,  1,  0,  0);
    drive(0,  4,  0, 0,  1,  0,  0,  1);   // pop over-request clamps to 1
    drive(4,  0,  0, 4,  0,  4,  0,  1);
    idle_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
